fpu_normalize: RTL and testbench

// Inverse of the FPU unpack stage: takes sign, unbiased exponent and an unpacked 64-bit

---
 rtl/fpu_normalize.sv | 211 +++++++++++++++++++++
 tb/tb_fpu_normalize.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_normalize.sv
// Normalise, round-to-nearest-even and pack an unpacked 64-bit mantissa into HALF/SINGLE/DOUBLE.
// Latency: accept edge to out_valid is N_shift+2 cycles (2 cycles for zero or reserved-type operands).
// Backpressure: one operand in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fpu_normalize #(
   parameter int SHIFT_STEP = 8,
   parameter int EXP_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_type,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [63:0]      in_mant,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_value,
   output logic             out_ovf,
   output logic             out_unf,
   output logic             out_inx,
   output logic             out_err
);

   // Two guard bits keep the exponent from wrapping during shifts and the round carry.
   localparam int XW = EXP_W + 2;

   typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

   state_t                state_q, state_d;
   logic [1:0]            type_q, type_d;
   logic                  sign_q, sign_d;
   logic signed [XW-1:0]  exp_q, exp_d;
   logic [63:0]           mant_q, mant_d;
   logic [63:0]           val_q, val_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  inx_q, inx_d;
   logic                  err_q, err_d;

   logic [4:0]            lz;
   logic                  lz_found;

   logic [51:0]           frac_w;
   logic                  guard_w, sticky_w, up_w, carry_w;
   logic [52:0]           frac_rnd;
   logic signed [XW-1:0]  bias_w, emax_w, biased_w;
   logic [10:0]           ef;
   logic [51:0]           ff;
   logic [63:0]           res_val;
   logic                  res_ovf, res_unf, res_inx, res_err;

   // Leading-zero count of the top SHIFT_STEP mantissa bits (SHIFT_STEP when all are zero).
   always_comb begin
      lz       = '0;
      lz_found = 1'b0;
      for (int i = 0; i < SHIFT_STEP; i++) begin
         if (!lz_found) begin
            if (mant_q[63-i]) lz_found = 1'b1;
            else              lz = lz + 5'd1;
         end
      end
   end

   // Round the normalised mantissa to nearest-even and build the packed result and flags.
   always_comb begin
      frac_w   = '0;
      guard_w  = 1'b0;
      sticky_w = 1'b0;
      bias_w   = XW'(1023);
      emax_w   = XW'(2047);
      case (type_q)
         2'b00: begin
            frac_w   = {42'b0, mant_q[62:53]};
            guard_w  = mant_q[52];
            sticky_w = |mant_q[51:0];
            bias_w   = XW'(15);
            emax_w   = XW'(31);
         end
         2'b01: begin
            frac_w   = {29'b0, mant_q[62:40]};
            guard_w  = mant_q[39];
            sticky_w = |mant_q[38:0];
            bias_w   = XW'(127);
            emax_w   = XW'(255);
         end
         default: begin
            frac_w   = mant_q[62:11];
            guard_w  = mant_q[10];
            sticky_w = |mant_q[9:0];
         end
      endcase

      up_w     = guard_w & (sticky_w | frac_w[0]);
      frac_rnd = {1'b0, frac_w} + {52'b0, up_w};
      // A carry out of the fraction means the significand rolled over to 2.0.
      case (type_q)
         2'b00:   carry_w = frac_rnd[10];
         2'b01:   carry_w = frac_rnd[23];
         default: carry_w = frac_rnd[52];
      endcase
      biased_w = exp_q + bias_w + $signed({{(XW-1){1'b0}}, carry_w});

      res_ovf = 1'b0;
      res_unf = 1'b0;
      res_inx = 1'b0;
      res_err = 1'b0;
      ef      = '0;
      ff      = '0;
      if (type_q == 2'b11) begin
         res_err = 1'b1;
      end else if (mant_q == '0) begin
         ef = '0;
      end else if (biased_w >= emax_w) begin
         ef      = emax_w[10:0];
         res_ovf = 1'b1;
         res_inx = 1'b1;
      end else if (biased_w[XW-1] || (biased_w == '0)) begin
         res_unf = 1'b1;
         res_inx = 1'b1;
      end else begin
         ef      = biased_w[10:0];
         ff      = frac_rnd[51:0];
         res_inx = guard_w | sticky_w;
      end

      case (type_q)
         2'b00:   res_val = {48'b0, sign_q, ef[4:0], ff[9:0]};
         2'b01:   res_val = {32'b0, sign_q, ef[7:0], ff[22:0]};
         default: res_val = {sign_q, ef, ff};
      endcase
      if (res_err) res_val = '0;
   end

   // Next-state and datapath update for the IDLE/SHIFT/ROUND/DONE sequence.
   always_comb begin
      state_d = state_q;
      type_d  = type_q;
      sign_d  = sign_q;
      exp_d   = exp_q;
      mant_d  = mant_q;
      val_d   = val_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      inx_d   = inx_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               type_d  = in_type;
               sign_d  = in_sign;
               exp_d   = {{2{in_exp[EXP_W-1]}}, in_exp};
               mant_d  = in_mant;
               state_d = ((in_mant == '0) || (in_type == 2'b11)) ? ROUND : SHIFT;
            end
         end
         SHIFT: begin
            mant_d = mant_q << lz;
            exp_d  = exp_q - $signed({{(XW-5){1'b0}}, lz});
            if (lz != 5'(SHIFT_STEP)) state_d = ROUND;
         end
         ROUND: begin
            val_d   = res_val;
            ovf_d   = res_ovf;
            unf_d   = res_unf;
            inx_d   = res_inx;
            err_d   = res_err;
            state_d = DONE;
         end
         default: begin
            if (out_ready) state_d = IDLE;
         end
      endcase
   end

   // State, operand and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         type_q  <= '0;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         mant_q  <= '0;
         val_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         inx_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         mant_q  <= mant_d;
         val_q   <= val_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         inx_q   <= inx_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_value = val_q;
   assign out_ovf   = ovf_q;
   assign out_unf   = unf_q;
   assign out_inx   = inx_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_fpu_normalize.sv
// Randomised scoreboard bench for fpu_normalize against an arithmetic reference model.
// Expected results are queued at accept; a monitor compares value, flags, latency and hold.
// The monitor drives random out_ready backpressure, with forced 5-cycle stalls on marked operands.
module tb_fpu_normalize;

   localparam int SHIFT_STEP = 8;

   typedef struct {
      logic [63:0] val;
      logic        ovf, unf, inx, err;
      int          lat;
      int          acc;
      bit          hold;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_type;
   logic        in_sign;
   logic [15:0] in_exp;
   logic [63:0] in_mant;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_value;
   logic        out_ovf, out_unf, out_inx, out_err;

   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   exp_t sb[$];

   fpu_normalize #(.SHIFT_STEP(SHIFT_STEP), .EXP_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_type(in_type), .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
      .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
      .out_ovf(out_ovf), .out_unf(out_unf), .out_inx(out_inx), .out_err(out_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Reference: value = m * 2^(e-63); round the exact significand with integer remainder arithmetic.
   function automatic exp_t model(input logic [1:0] t, input logic s, input logic [15:0] e,
                                  input logic [63:0] m);
      exp_t r;
      int F, EB, bias, emax, p, lz, E, b, sh;
      logic [63:0] norm, kept, rem, half, one;
      r = '{val: 64'd0, ovf: 1'b0, unf: 1'b0, inx: 1'b0, err: 1'b0, lat: 2, acc: 0, hold: 1'b0};
      case (t)
         2'b00:   begin F = 10; EB = 5;  bias = 15;   end
         2'b01:   begin F = 23; EB = 8;  bias = 127;  end
         default: begin F = 52; EB = 11; bias = 1023; end
      endcase
      if (t == 2'b11) begin
         r.err = 1'b1;
         return r;
      end
      if (m == 64'd0) begin
         r.val = 64'(s) << (F + EB);
         return r;
      end
      p = 0;
      for (int i = 0; i < 64; i++) if (m[i]) p = i;
      lz   = 63 - p;
      E    = int'($signed(e)) - lz;
      norm = m << lz;
      sh   = 63 - F;
      one  = 64'd1;
      kept = norm >> sh;
      rem  = norm & ((one << sh) - one);
      half = one << (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
      if (kept == (one << (F + 1))) begin
         kept = kept >> 1;
         E    = E + 1;
      end
      r.inx = (rem != 64'd0);
      b     = E + bias;
      emax  = (1 << EB) - 1;
      if (b >= emax) begin
         r.val = (64'(s) << (F + EB)) | (64'(emax) << F);
         r.ovf = 1'b1;
         r.inx = 1'b1;
      end else if (b <= 0) begin
         r.val = 64'(s) << (F + EB);
         r.unf = 1'b1;
         r.inx = 1'b1;
      end else begin
         r.val = (64'(s) << (F + EB)) | (64'(b) << F) | (kept & ((one << F) - one));
      end
      r.lat = lz / SHIFT_STEP + 3;
      return r;
   endfunction

   // Issue one operand; entered and left just after a falling edge.
   task automatic send(input logic [1:0] t, input logic s, input logic [15:0] e,
                       input logic [63:0] m, input bit hold);
      exp_t x;
      int   w;
      x      = model(t, s, e, m);
      x.hold = hold;
      in_type  = t;
      in_sign  = s;
      in_exp   = e;
      in_mant  = m;
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         n_vec++;
         n_bad++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
         in_valid = 1'b0;
         return;
      end
      x.acc = cyc + 1;
      sb.push_back(x);
      @(negedge clk);
      in_valid = 1'b0;
      in_mant  = {$urandom, $urandom};
      in_exp   = 16'($urandom);
      in_type  = 2'($urandom);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 500) begin
         @(negedge clk);
         w++;
      end
   endtask

   // Monitor: compare each result on first sight, then check it stays stable while stalled.
   initial begin
      exp_t cur;
      bit   first;
      int   wait_cnt, hold_left;
      out_ready = 1'b0;
      first     = 1'b1;
      wait_cnt  = 0;
      hold_left = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            first     = 1'b1;
            wait_cnt  = 0;
            hold_left = 0;
            out_ready = 1'b0;
            continue;
         end
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_out_valid", 64'(out_valid), 64'd0);
               out_ready = 1'b1;
            end else begin
               if (first) begin
                  cur = sb[0];
                  chk("value", out_value, cur.val);
                  chk("flags_ovf_unf_inx_err", {60'd0, out_ovf, out_unf, out_inx, out_err},
                      {60'd0, cur.ovf, cur.unf, cur.inx, cur.err});
                  chk("latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
                  first     = 1'b0;
                  hold_left = cur.hold ? 5 : 0;
               end else begin
                  chk("held_value", out_value, cur.val);
                  chk("held_flags", {60'd0, out_ovf, out_unf, out_inx, out_err},
                      {60'd0, cur.ovf, cur.unf, cur.inx, cur.err});
                  chk("in_ready_in_done", 64'(in_ready), 64'd0);
               end
               if (hold_left > 0) begin
                  out_ready = 1'b0;
                  hold_left--;
               end else begin
                  out_ready = ($urandom_range(0, 3) != 0);
               end
               if (out_ready) begin
                  void'(sb.pop_front());
                  first    = 1'b1;
                  wait_cnt = 0;
               end
            end
         end else begin
            out_ready = 1'($urandom_range(0, 1));
            if (sb.size() != 0) begin
               wait_cnt++;
               if (wait_cnt > 200) begin
                  n_vec++;
                  n_bad++;
                  $display("FAIL out_valid_timeout: got 0 expected 1");
                  void'(sb.pop_front());
                  wait_cnt = 0;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got running expected finished");
      $fatal(1, "watchdog expired");
   end

   // Stimulus: reset checks, directed corner cases, random operands, mid-flight reset.
   initial begin
      int   lim, ev;
      logic [1:0]  t;
      logic [63:0] m;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_type  = 2'b00;
      in_sign  = 1'b0;
      in_exp   = 16'd0;
      in_mant  = 64'd0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_value", out_value, 64'd0);
      chk("rst_flags", {60'd0, out_ovf, out_unf, out_inx, out_err}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      send(2'b01, 1'b0, 16'd0,     64'h8000_0000_0000_0000, 1'b0);
      send(2'b10, 1'b0, 16'd0,     64'h0000_0000_0000_0001, 1'b0);
      send(2'b00, 1'b0, 16'd0,     64'h8030_0000_0000_0000, 1'b0);
      send(2'b00, 1'b0, 16'd0,     64'h8010_0000_0000_0000, 1'b0);
      send(2'b01, 1'b0, 16'd128,   64'h8000_0000_0000_0000, 1'b0);
      send(2'b01, 1'b1, 16'd128,   64'h8000_0000_0000_0000, 1'b0);
      send(2'b10, 1'b0, -16'sd1100, 64'h8000_0000_0000_0000, 1'b0);
      send(2'b10, 1'b1, 16'd0,     64'd0,                   1'b0);
      send(2'b11, 1'b0, 16'd5,     64'h1234_5678_9ABC_DEF0, 1'b0);
      send(2'b01, 1'b1, 16'd3,     64'h00C0_0000_0000_0001, 1'b1);
      send(2'b01, 1'b0, 16'd127,   64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      send(2'b00, 1'b0, -16'sd14,  64'h8000_0000_0000_0000, 1'b0);
      send(2'b00, 1'b1, -16'sd15,  64'h8000_0000_0000_0000, 1'b0);
      send(2'b00, 1'b0, 16'd15,    64'hFFF0_0000_0000_0000, 1'b0);
      send(2'b10, 1'b0, 16'h7FFF,  64'h0000_0000_0000_00FF, 1'b0);
      send(2'b10, 1'b1, 16'h8000,  64'h8000_0000_0000_0000, 1'b0);

      for (int k = 0; k < 300; k++) begin
         t = 2'($urandom_range(0, 15) == 0 ? 3 : $urandom_range(0, 2));
         lim = (t == 2'b00) ? 40 : (t == 2'b01) ? 160 : 1100;
         ev  = $urandom_range(0, 2 * lim) - lim;
         m   = {$urandom, $urandom} >> $urandom_range(0, 63);
         if ($urandom_range(0, 19) == 0) m = 64'd0;
         send(t, 1'($urandom), 16'(ev), m, ($urandom_range(0, 19) == 0));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();

      send(2'b10, 1'b0, 16'd0, 64'h0000_0000_0000_0001, 1'b0);
      @(negedge clk);
      chk("busy_in_ready", 64'(in_ready), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 64'(out_valid), 64'd0);
      chk("async_rst_in_ready", 64'(in_ready), 64'd1);
      chk("async_rst_out_value", out_value, 64'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(2'b00, 1'b1, 16'd1, 64'h0C00_0000_0000_0000, 1'b0);
      drain();
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
